axi_read_responder: RTL

AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

---
 rtl/axi_read_responder.sv | 97 +++++++++
 1 files changed

// File: rtl/axi_read_responder.sv
// axi_read_responder: single-outstanding AXI4 read responder that returns address-pattern data.
// Optional macro RD_STALL_INJECT_EN inserts a one-cycle rvalid gap after every fourth non-last beat.
module axi_read_responder #(
   parameter int C_AXI_ID_WIDTH   = 1,
   parameter int C_AXI_ADDR_WIDTH = 12,
   parameter int C_AXI_DATA_WIDTH = 128
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        s_axi_arvalid,
   input  logic [C_AXI_ID_WIDTH-1:0]   s_axi_arid,
   input  logic [C_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]                  s_axi_arlen,
   input  logic [2:0]                  s_axi_arsize,
   input  logic [1:0]                  s_axi_arburst,
   output logic                        s_axi_arready,
   output logic                        s_axi_rvalid,
   output logic [C_AXI_ID_WIDTH-1:0]   s_axi_rid,
   output logic [C_AXI_DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]                  s_axi_rresp,
   output logic                        s_axi_rlast,
   input  logic                        s_axi_rready
);
   localparam int NB = C_AXI_DATA_WIDTH / 8;
   typedef enum logic {IDLE, BURST} state_t;
   state_t state, state_next;
   logic init_q, err_q, incr_q, stall_q, fire, last;
   logic [C_AXI_ID_WIDTH-1:0] id_q;
   logic [C_AXI_ADDR_WIDTH-1:0] addr_q;
   logic [7:0] len_q, beat_q, base;
   logic [2:0] size_q;
   logic [C_AXI_DATA_WIDTH-1:0] data;

   // state register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_next;

   // next state and handshake outputs; arready waits one edge after reset release
   always_comb begin
      state_next = state;
      s_axi_arready = state == IDLE && init_q;
      s_axi_rvalid = state == BURST && !stall_q;
      if (s_axi_arvalid && s_axi_arready) state_next = BURST;
      if (s_axi_rvalid && s_axi_rready && last) state_next = IDLE;
   end

   assign fire = s_axi_rvalid && s_axi_rready;
   assign last = beat_q == len_q;

   // latch the request, then step beat count and (for INCR) address on each completed beat
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         init_q <= 1'b0;
         err_q  <= 1'b0;
         incr_q <= 1'b0;
         id_q   <= '0;
         addr_q <= '0;
         len_q  <= '0;
         size_q <= '0;
         beat_q <= '0;
      end else begin
         init_q <= 1'b1;
         if (s_axi_arvalid && s_axi_arready) begin
            id_q   <= s_axi_arid;
            addr_q <= s_axi_araddr;
            len_q  <= s_axi_arlen;
            size_q <= s_axi_arsize;
            beat_q <= '0;
            incr_q <= s_axi_arburst == 2'b01;
            err_q  <= s_axi_arburst[1] || (32'd1 << s_axi_arsize) > 32'(NB);
         end else if (fire) begin
            beat_q <= beat_q + 8'd1;
            if (incr_q) addr_q <= addr_q + (C_AXI_ADDR_WIDTH'(1) << size_q);
         end
      end

`ifdef RD_STALL_INJECT_EN
   // one idle cycle after each completed non-last beat whose index ends in 2'b11
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) stall_q <= 1'b0;
      else stall_q <= fire && !last && beat_q[1:0] == 2'b11;
`else
   assign stall_q = 1'b0;
`endif

   assign base = addr_q[7:0] & ~8'(NB - 1);

   for (genvar i = 0; i < NB; i++) begin : g_lane
      assign data[8*i +: 8] = base + 8'(i);
   end

   assign s_axi_rdata = (s_axi_rvalid && !err_q) ? data : '0;
   assign s_axi_rresp = (s_axi_rvalid && err_q) ? 2'b10 : 2'b00;
   assign s_axi_rlast = s_axi_rvalid && last;
   assign s_axi_rid   = s_axi_rvalid ? id_q : '0;
endmodule
